// File: rtl/oled_pixel_streamer.sv
// SSD1331 PmodOLED driver: power/reset/config sequencing followed by continuous
// RGB565 frame streaming over a 4-wire SPI link (mode 3, MSB first).
module oled_pixel_streamer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESET_CYCLES = 100,
  parameter int unsigned PIXEL_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam int unsigned WAIT_MAX   = (RESET_CYCLES > PIXEL_LAT) ? RESET_CYCLES : PIXEL_LAT;
  localparam int unsigned CW         = $clog2(WAIT_MAX + 1);
  localparam int unsigned DW         = $clog2(CLK_DIV + 1);
  localparam int unsigned LAST_PIXEL = 6143;
  localparam int unsigned INIT_BYTES = 9;

  typedef enum logic [3:0] {
    POWER_UP, RES_LOW, RES_WAIT, INIT_CMD, VCC_WAIT, DISP_ON, PIX_FETCH, PIX_HI, PIX_LO
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic [3:0]    cmd_idx, cmd_idx_n;
  logic [7:0]    lo_byte, lo_byte_n;
  logic          active, active_n;
  logic [4:0]    phase, phase_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [12:0]   pixel_index_n;
  logic          frame_begin_n, sending_pixels_n;
  logic          cs_n, sclk_n, sdin_n, d_cn_n, resn_n, vccen_n, pmoden_n;
  logic          start_c, byte_done_c;
  logic [7:0]    start_byte_c;

  // Panel configuration: display off, remap/colour depth, column and row windows.
  function automatic logic [7:0] init_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    init_rom = 8'hAE;
      4'd1:    init_rom = 8'hA0;
      4'd2:    init_rom = 8'h72;
      4'd3:    init_rom = 8'h15;
      4'd4:    init_rom = 8'h00;
      4'd5:    init_rom = 8'h5F;
      4'd6:    init_rom = 8'h75;
      4'd7:    init_rom = 8'h00;
      4'd8:    init_rom = 8'h3F;
      default: init_rom = 8'h00;
    endcase
  endfunction

  assign byte_done_c = active && (phase == 5'd16) && (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= POWER_UP;
      wait_cnt       <= '0;
      cmd_idx        <= '0;
      lo_byte        <= '0;
      active         <= 1'b0;
      phase          <= '0;
      div_cnt        <= '0;
      shreg          <= '0;
      pixel_index    <= '0;
      frame_begin    <= 1'b0;
      sending_pixels <= 1'b0;
      cs             <= 1'b1;
      sclk           <= 1'b1;
      sdin           <= 1'b0;
      d_cn           <= 1'b0;
      resn           <= 1'b0;
      vccen          <= 1'b0;
      pmoden         <= 1'b0;
    end else begin
      state          <= state_n;
      wait_cnt       <= wait_cnt_n;
      cmd_idx        <= cmd_idx_n;
      lo_byte        <= lo_byte_n;
      active         <= active_n;
      phase          <= phase_n;
      div_cnt        <= div_cnt_n;
      shreg          <= shreg_n;
      pixel_index    <= pixel_index_n;
      frame_begin    <= frame_begin_n;
      sending_pixels <= sending_pixels_n;
      cs             <= cs_n;
      sclk           <= sclk_n;
      sdin           <= sdin_n;
      d_cn           <= d_cn_n;
      resn           <= resn_n;
      vccen          <= vccen_n;
      pmoden         <= pmoden_n;
    end
  end

  always_comb begin
    state_n          = state;
    wait_cnt_n       = wait_cnt;
    cmd_idx_n        = cmd_idx;
    lo_byte_n        = lo_byte;
    active_n         = active;
    phase_n          = phase;
    div_cnt_n        = div_cnt;
    shreg_n          = shreg;
    pixel_index_n    = pixel_index;
    frame_begin_n    = 1'b0;
    sending_pixels_n = sending_pixels;
    cs_n             = cs;
    sclk_n           = sclk;
    sdin_n           = sdin;
    d_cn_n           = d_cn;
    resn_n           = resn;
    vccen_n          = vccen;
    pmoden_n         = 1'b1;
    start_c          = 1'b0;
    start_byte_c     = 8'h00;

    case (state)
      // First clock raises pmoden, then RESET_CYCLES of settling.
      POWER_UP: begin
        resn_n = 1'b0;
        if (wait_cnt == CW'(RESET_CYCLES)) begin
          state_n    = RES_LOW;
          wait_cnt_n = '0;
        end else wait_cnt_n = wait_cnt + CW'(1);
      end
      RES_LOW: begin
        resn_n = 1'b0;
        if (wait_cnt == CW'(RESET_CYCLES - 1)) begin
          state_n    = RES_WAIT;
          resn_n     = 1'b1;
          wait_cnt_n = '0;
        end else wait_cnt_n = wait_cnt + CW'(1);
      end
      RES_WAIT: begin
        if (wait_cnt == CW'(RESET_CYCLES - 1)) begin
          state_n      = INIT_CMD;
          wait_cnt_n   = '0;
          start_c      = 1'b1;
          start_byte_c = init_rom(4'd0);
          cmd_idx_n    = 4'd1;
        end else wait_cnt_n = wait_cnt + CW'(1);
      end
      INIT_CMD: begin
        if (byte_done_c) begin
          if (cmd_idx == 4'(INIT_BYTES)) begin
            state_n = VCC_WAIT;
            vccen_n = 1'b1;
          end else begin
            start_c      = 1'b1;
            start_byte_c = init_rom(cmd_idx);
            cmd_idx_n    = cmd_idx + 4'd1;
          end
        end
      end
      VCC_WAIT: begin
        if (wait_cnt == CW'(RESET_CYCLES - 1)) begin
          state_n      = DISP_ON;
          wait_cnt_n   = '0;
          start_c      = 1'b1;
          start_byte_c = 8'hAF;
        end else wait_cnt_n = wait_cnt + CW'(1);
      end
      // d_cn goes high here, at least PIXEL_LAT cycles before the first pixel cs fall.
      DISP_ON: begin
        if (byte_done_c) begin
          state_n          = PIX_FETCH;
          sending_pixels_n = 1'b1;
          d_cn_n           = 1'b1;
          wait_cnt_n       = '0;
        end
      end
      PIX_FETCH: begin
        if (wait_cnt == CW'(PIXEL_LAT - 1)) begin
          state_n      = PIX_HI;
          wait_cnt_n   = '0;
          start_c      = 1'b1;
          start_byte_c = pixel_data[15:8];
          lo_byte_n    = pixel_data[7:0];
        end else wait_cnt_n = wait_cnt + CW'(1);
      end
      PIX_HI: begin
        if (byte_done_c) begin
          state_n      = PIX_LO;
          start_c      = 1'b1;
          start_byte_c = lo_byte;
        end
      end
      PIX_LO: begin
        if (byte_done_c) begin
          state_n    = PIX_FETCH;
          wait_cnt_n = '0;
          if (pixel_index == 13'(LAST_PIXEL)) begin
            pixel_index_n = '0;
            frame_begin_n = 1'b1;
          end else pixel_index_n = pixel_index + 13'd1;
        end
      end
      default: state_n = POWER_UP;
    endcase

    // Byte shifter: phases 0..15 alternate sclk low/high, phase 16 is the cs-high gap.
    if (start_c) begin
      active_n  = 1'b1;
      phase_n   = '0;
      div_cnt_n = '0;
      shreg_n   = start_byte_c;
      sdin_n    = start_byte_c[7];
      cs_n      = 1'b0;
      sclk_n    = 1'b0;
    end else if (active) begin
      if (div_cnt == DW'(CLK_DIV - 1)) begin
        div_cnt_n = '0;
        if (phase == 5'd16) begin
          active_n = 1'b0;
        end else begin
          phase_n = phase + 5'd1;
          if (phase == 5'd15) begin
            cs_n   = 1'b1;
            sclk_n = 1'b1;
          end else if (!phase[0]) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n  = 1'b0;
            sdin_n  = shreg[6];
            shreg_n = {shreg[6:0], 1'b0};
          end
        end
      end else div_cnt_n = div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer: decodes the SPI stream and checks power
// sequencing, init ROM, pixel bytes, frame wrap and mid-byte reset recovery.
module tb_oled_pixel_streamer;

  localparam int unsigned CLK_DIV      = 1;
  localparam int unsigned RESET_CYCLES = 4;
  localparam int unsigned PIXEL_LAT    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pixel_data = '0;
  logic [12:0] pixel_index;
  logic        frame_begin, sending_pixels, cs, sclk, sdin, d_cn, resn, vccen, pmoden;

  always #5 clock = ~clock;

  oled_pixel_streamer #(
    .CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES), .PIXEL_LAT(PIXEL_LAT)
  ) dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_index(pixel_index),
    .frame_begin(frame_begin), .sending_pixels(sending_pixels), .cs(cs), .sclk(sclk),
    .sdin(sdin), .d_cn(d_cn), .resn(resn), .vccen(vccen), .pmoden(pmoden)
  );

  // Pixel source: one register stage, so data is ready PIXEL_LAT=2 cycles after an index change.
  always @(posedge clock) pixel_data <= {3'b000, pixel_index};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Event log, cleared while reset is high; times are cycles since reset release.
  int rel = 0;
  int byte_q[$], cs_fall_q[$], cs_rise_q[$], idx_chg_q[$], idx_val_q[$], fb_q[$], fb_idx_q[$];
  int pmoden_t = -1, resn_t = -1, vccen_t = -1, send_t = -1;
  int nbits = 0;
  logic [7:0]  sh = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [12:0] prev_idx = '0;

  always @(posedge clock) rel <= reset ? 0 : rel + 1;

  always @(negedge clock) begin
    if (reset) begin
      byte_q.delete(); cs_fall_q.delete(); cs_rise_q.delete();
      idx_chg_q.delete(); idx_val_q.delete(); fb_q.delete(); fb_idx_q.delete();
      pmoden_t = -1; resn_t = -1; vccen_t = -1; send_t = -1; nbits = 0;
    end else begin
      if (prev_cs && !cs) cs_fall_q.push_back(rel);
      if (!prev_cs && cs) cs_rise_q.push_back(rel);
      if (cs) nbits = 0;
      else if (sclk && !prev_sclk) begin
        sh = {sh[6:0], sdin};
        nbits++;
        if (nbits == 8) begin
          byte_q.push_back(int'({d_cn, sh}));
          nbits = 0;
        end
      end
      if (pixel_index != prev_idx) begin
        idx_chg_q.push_back(rel);
        idx_val_q.push_back(int'(pixel_index));
      end
      if (frame_begin) begin
        fb_q.push_back(rel);
        fb_idx_q.push_back(int'(pixel_index));
      end
      if (pmoden && pmoden_t < 0) pmoden_t = rel;
      if (resn && resn_t < 0) resn_t = rel;
      if (vccen && vccen_t < 0) vccen_t = rel;
      if (sending_pixels && send_t < 0) send_t = rel;
    end
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_idx  = pixel_index;
  end

  typedef struct {
    string      name;
    logic [7:0] val;
    logic       dcn;
  } vec_t;

  vec_t tbl[22];
  int   wrap_idx[5] = '{6141, 6142, 6143, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, nb0, cnt;
    logic [12:0] last;

    tbl[0]  = '{"cmd_ae", 8'hAE, 1'b0};
    tbl[1]  = '{"cmd_a0", 8'hA0, 1'b0};
    tbl[2]  = '{"cmd_72", 8'h72, 1'b0};
    tbl[3]  = '{"cmd_15", 8'h15, 1'b0};
    tbl[4]  = '{"cmd_00a", 8'h00, 1'b0};
    tbl[5]  = '{"cmd_5f", 8'h5F, 1'b0};
    tbl[6]  = '{"cmd_75", 8'h75, 1'b0};
    tbl[7]  = '{"cmd_00b", 8'h00, 1'b0};
    tbl[8]  = '{"cmd_3f", 8'h3F, 1'b0};
    tbl[9]  = '{"cmd_af", 8'hAF, 1'b0};
    tbl[10] = '{"pix0_hi", 8'h00, 1'b1};
    tbl[11] = '{"pix0_lo", 8'h00, 1'b1};
    tbl[12] = '{"pix1_hi", 8'h00, 1'b1};
    tbl[13] = '{"pix1_lo", 8'h01, 1'b1};
    tbl[14] = '{"pix2_hi", 8'h00, 1'b1};
    tbl[15] = '{"pix2_lo", 8'h02, 1'b1};
    tbl[16] = '{"pix3_hi", 8'h00, 1'b1};
    tbl[17] = '{"pix3_lo", 8'h03, 1'b1};
    tbl[18] = '{"pix4_hi", 8'h00, 1'b1};
    tbl[19] = '{"pix4_lo", 8'h04, 1'b1};
    tbl[20] = '{"pix5_hi", 8'h00, 1'b1};
    tbl[21] = '{"pix5_lo", 8'h05, 1'b1};

    // Reset values: {cs,sclk,sdin,d_cn,resn,vccen,pmoden,frame_begin,sending_pixels}
    repeat (5) @(posedge clock);
    #1;
    check("reset_ctrl", 32'({cs, sclk, sdin, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels}),
          32'h180);
    check("reset_index", 32'(pixel_index), 32'd0);
    #1 reset = 1'b0;

    for (int c = 0; c < 2000 && idx_val_q.size() < 6; c++) @(posedge clock);
    #1;
    check("stream_start", 32'(idx_val_q.size() >= 6), 32'd1);

    check("pmoden_rise", pmoden_t, 32'd1);
    check("resn_rise", resn_t, 32'd9);
    check("first_cs_fall", qget(cs_fall_q, 0), 32'd13);
    check("first_cs_low_len", qget(cs_rise_q, 0) - qget(cs_fall_q, 0), 32'd16);
    check("inter_byte_gap", qget(cs_fall_q, 1) - qget(cs_rise_q, 0), 32'd1);

    for (int i = 0; i < 22; i++)
      check(tbl[i].name, qget(byte_q, i), 32'({tbl[i].dcn, tbl[i].val}));

    check("vccen_after_3f", vccen_t - qget(cs_rise_q, 8), 32'd1);
    check("af_after_vcc_wait", qget(cs_fall_q, 9) - vccen_t, 32'd4);
    cnt = 0;
    foreach (byte_q[i]) if (byte_q[i] == 32'h0AF) cnt++;
    check("af_count", cnt, 32'd1);
    check("sending_after_af", send_t - qget(cs_fall_q, 9), 32'd17);
    check("first_index_step", qget(idx_chg_q, 0) - send_t, 32'd36);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("index_val%0d", i), qget(idx_val_q, i), 32'(i + 1));
      if (i > 0)
        check($sformatf("index_period%0d", i), qget(idx_chg_q, i) - qget(idx_chg_q, i - 1), 32'd36);
    end
    check("no_early_frame_begin", fb_q.size(), 32'd0);

    // Jump to the end of the frame right after an index step, while the FSM is fetching.
    last = pixel_index;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      if (pixel_index != last) break;
    end
    check("pre_wrap_step", 32'(pixel_index != last), 32'd1);
    n0  = idx_val_q.size();
    nb0 = byte_q.size();
    force dut.pixel_index = 13'd6141;
    @(posedge clock); #1;
    release dut.pixel_index;

    for (int c = 0; c < 1000 && idx_val_q.size() < n0 + 5; c++) @(posedge clock);
    #1;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("wrap_index%0d", j), qget(idx_val_q, n0 + j), wrap_idx[j]);
      if (j > 0)
        check($sformatf("wrap_period%0d", j), qget(idx_chg_q, n0 + j) - qget(idx_chg_q, n0 + j - 1),
              32'd36);
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("wrap_hi%0d", wrap_idx[j]), qget(byte_q, nb0 + 2 * j),
            32'h100 | 32'(wrap_idx[j] >> 8));
      check($sformatf("wrap_lo%0d", wrap_idx[j]), qget(byte_q, nb0 + 2 * j + 1),
            32'h100 | 32'(wrap_idx[j] & 8'hFF));
    end
    check("frame_begin_count", fb_q.size(), 32'd1);
    check("frame_begin_time", qget(fb_q, 0), qget(idx_chg_q, n0 + 3));
    check("frame_begin_index", qget(fb_idx_q, 0), 32'd0);

    // Reset in the middle of a high-byte transfer.
    last = pixel_index;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      if (pixel_index != last) break;
    end
    repeat (5) @(posedge clock);
    #1;
    check("pre_reset_cs_low", 32'({cs, d_cn}), 32'b01);
    #1 reset = 1'b1;
    #1;
    check("midreset_ctrl", 32'({cs, sclk, resn, vccen, pmoden, sending_pixels, d_cn}), 32'b1100000);
    check("midreset_index", 32'(pixel_index), 32'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    for (int c = 0; c < 200 && (byte_q.size() < 1 || cs_rise_q.size() < 1); c++) @(posedge clock);
    #1;
    check("replay_pmoden_rise", pmoden_t, 32'd1);
    check("replay_resn_rise", resn_t, 32'd9);
    check("replay_cs_fall", qget(cs_fall_q, 0), 32'd13);
    check("replay_cs_low_len", qget(cs_rise_q, 0) - qget(cs_fall_q, 0), 32'd16);
    check("replay_cmd_ae", qget(byte_q, 0), 32'h0AE);
    check("replay_not_sending", 32'(sending_pixels), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_pixel_streamer.md
# oled_pixel_streamer

Drives the 96x64 16-bit-colour PmodOLED (SSD1331) over its 4-wire SPI port. It sits on the other side of the pixel-colour generators: it sequences `pixel_index`, captures the returned `pixel_data`, and serialises every pixel to the panel. It also owns the panel power-up, reset and configuration sequence, and then refreshes frames continuously.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clock` cycles (≥1).
- `RESET_CYCLES`, default 100: length in `clock` cycles of each power/reset wait interval (≥1).
- `PIXEL_LAT`, default 2: `clock` cycles from a `pixel_index` change to a valid `pixel_data` (≥1).
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pixel_data`  in  16  RGB565 colour for the current `pixel_index`.
- `pixel_index`  out  13  pixel address, 0..6143, row-major (x = index mod 96, y = index / 96).
- `frame_begin`  out  1  one-cycle pulse when `pixel_index` returns to 0 during streaming.
- `sending_pixels`  out  1  high once the init sequence is complete (streaming state).
- `cs`  out  1  SPI chip select, active low.
- `sclk`  out  1  SPI clock, idles high.
- `sdin`  out  1  SPI data, MSB first.
- `d_cn`  out  1  0 = command byte, 1 = pixel data byte.
- `resn`  out  1  panel reset, active low.
- `vccen`  out  1  panel VCC enable.
- `pmoden`  out  1  Pmod logic power enable.

## Operation
- Reset values (async, immediate):
  - `cs`=1, `sclk`=1, `sdin`=0, `d_cn`=0.
  - `resn`=0, `vccen`=0, `pmoden`=0.
  - `pixel_index`=0, `frame_begin`=0, `sending_pixels`=0.
  - FSM enters POWER_UP.
- FSM states:
  - POWER_UP: `pmoden`=1; wait RESET_CYCLES, then go to RES_LOW.
  - RES_LOW: `resn`=0 for RESET_CYCLES, then go to RES_WAIT.
  - RES_WAIT: `resn`=1; wait RESET_CYCLES, then go to INIT_CMD.
  - INIT_CMD: send the 9-byte ROM sequence AE, A0, 72, 15, 00, 5F, 75, 00, 3F with `d_cn`=0, then go to VCC_WAIT.
  - VCC_WAIT: `vccen`=1; wait RESET_CYCLES, then go to DISP_ON.
  - DISP_ON: send AF with `d_cn`=0; then `sending_pixels`=1 and go to PIX_FETCH.
  - PIX_FETCH: `pixel_index` is stable; wait PIXEL_LAT cycles, latch `pixel_data`, go to PIX_HI.
  - PIX_HI: send bits [15:8] with `d_cn`=1, then go to PIX_LO.
  - PIX_LO: send bits [7:0] with `d_cn`=1.
    - On byte completion, `pixel_index` advances (6143 wraps to 0) and the FSM returns to PIX_FETCH.
    - `frame_begin` pulses in the same cycle the wrap to 0 occurs.
- Byte shifter, shared by all SPI states:
  - `cs`=0 for the whole byte.
  - Per bit, MSB first: `sclk`=0 for CLK_DIV cycles with `sdin` updated on entry to the low phase, then `sclk`=1 for CLK_DIV cycles. The panel samples on the rising edge.
  - After bit 0, `cs`=1 and `sclk`=1 for CLK_DIV cycles (inter-byte gap). The byte is then done.
- `d_cn` is set before `cs` falls and held until `cs` rises.
- `pixel_data` is sampled only at the end of PIX_FETCH; changes at any other time are ignored.
- Frames stream back-to-back with no idle time; `sending_pixels` stays 1 until reset.

## Timing
- Byte time = 17·CLK_DIV cycles (16 bit-phases + 1 gap).
- Pixel time = PIXEL_LAT + 34·CLK_DIV cycles.
- Frame time = 6144 × pixel time.
- From `reset` deassertion:
  - `pmoden`=1 on the first clock.
  - `resn` rises 2·RESET_CYCLES after that.
  - The first `cs` fall occurs RESET_CYCLES after `resn` rises.
- After INIT_CMD completes, `vccen` rises on the next cycle.
- After VCC_WAIT, AF is sent; `sending_pixels` rises the cycle after AF's gap ends.
- `pixel_index` changes only in the cycle after a PIX_LO gap ends. It is otherwise constant.
- Reset asserted mid-operation (mid-byte included):
  - All outputs return to reset values within the same cycle; no partial byte completes.
  - On release, the full power sequence restarts.

## Test plan
- Reset values: assert `reset` for 5 cycles → every output equals its reset value. Release with RESET_CYCLES=4 → `pmoden`=1 on the first clock, `resn` rises 8 cycles later, first `cs` fall 4 cycles after that.
- First command byte, CLK_DIV=1 → `cs` low for 16 cycles, `d_cn`=0, and `sdin` sampled on the 8 `sclk` rising edges reads 1010_1110 (AE). Next `cs` fall follows a 1-cycle gap. All 9 init bytes match the ROM.
- Power order → `vccen` rises only after the byte 3F completes; exactly one AF follows RESET_CYCLES later; `sending_pixels` rises after AF.
- Pixel stream, with the bench returning `pixel_data` = {3'b0, `pixel_index`} after PIXEL_LAT=2 → bytes for index 5 are 00, 05 with `d_cn`=1. Index increments by exactly 1 per 34·CLK_DIV+2 cycles.
- Frame wrap → after index 6143's low byte, `pixel_index`=0 and `frame_begin`=1 for exactly one cycle; no other `frame_begin` pulses occur within the frame.
- Mid-byte reset during PIX_HI → immediate `cs`=1, `resn`=0, `pixel_index`=0, `sending_pixels`=0. After release, the power-up sequence and AE are replayed exactly as in the first scenario.
